// File: rtl/cpu_control_sequencer.sv
// Fetch/decode/execute control sequencer for the 8-bit bus CPU.
// Control outputs are a combinational decode of the registered T-state, the opcode,
// the flags and the halted state; the T-state counter and the flags are registered.
module cpu_control_sequencer #(
    parameter int unsigned MAX_STEPS  = 5,
    parameter logic        ALU_OP_ADD = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   opcode,
    input  logic                         carry_in,
    input  logic                         zero_in,
    output logic                         pc_out,
    output logic                         pc_inc,
    output logic                         pc_load,
    output logic                         mar_in,
    output logic                         ram_out,
    output logic                         ram_in,
    output logic                         ir_in,
    output logic                         ir_out,
    output logic                         a_in,
    output logic                         a_out,
    output logic                         b_in,
    output logic                         alu_en,
    output logic                         alu_op,
    output logic                         out_in,
    output logic                         halt,
    output logic                         flag_c,
    output logic                         flag_z,
    output logic [$clog2(MAX_STEPS)-1:0] step
);

    localparam int unsigned StepW = $clog2(MAX_STEPS);

    localparam logic [StepW-1:0] Step0 = StepW'(0);
    localparam logic [StepW-1:0] Step1 = StepW'(1);
    localparam logic [StepW-1:0] Step2 = StepW'(2);
    localparam logic [StepW-1:0] Step3 = StepW'(3);
    localparam logic [StepW-1:0] Step4 = StepW'(4);

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpSta = 4'h4;
    localparam logic [3:0] OpLdi = 4'h5;
    localparam logic [3:0] OpJmp = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpOut = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    typedef enum logic {StRun, StHalted} state_e;

    state_e           state_q, state_d;
    logic [StepW-1:0] step_q, step_d;
    logic             flag_c_q, flag_z_q;
    logic             flag_load;
    logic             instr_end;

    // State, step counter and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            step_q   <= Step0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (flag_load) begin
                flag_c_q <= carry_in;
                flag_z_q <= zero_in;
            end
        end
    end

    // Control-word decode and next-state logic.
    always_comb begin
        pc_out    = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        mar_in    = 1'b0;
        ram_out   = 1'b0;
        ram_in    = 1'b0;
        ir_in     = 1'b0;
        ir_out    = 1'b0;
        a_in      = 1'b0;
        a_out     = 1'b0;
        b_in      = 1'b0;
        alu_en    = 1'b0;
        alu_op    = ALU_OP_ADD;
        out_in    = 1'b0;
        halt      = 1'b0;
        flag_load = 1'b0;
        instr_end = 1'b0;
        state_d   = state_q;
        step_d    = step_q;

        if (rst) begin
            // Everything stays deasserted; the register block handles the reset itself.
        end else if (state_q == StHalted) begin
            halt = 1'b1;
        end else begin
            case (step_q)
                Step0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                Step1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_inc  = 1'b1;
                end
                Step2: begin
                    unique case (opcode)
                        OpLda, OpAdd, OpSub, OpSta: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        OpLdi: begin
                            ir_out    = 1'b1;
                            a_in      = 1'b1;
                            instr_end = 1'b1;
                        end
                        OpJmp: begin
                            ir_out    = 1'b1;
                            pc_load   = 1'b1;
                            instr_end = 1'b1;
                        end
                        OpJc: begin
                            ir_out    = flag_c_q;
                            pc_load   = flag_c_q;
                            instr_end = 1'b1;
                        end
                        OpJz: begin
                            ir_out    = flag_z_q;
                            pc_load   = flag_z_q;
                            instr_end = 1'b1;
                        end
                        OpOut: begin
                            a_out     = 1'b1;
                            out_in    = 1'b1;
                            instr_end = 1'b1;
                        end
                        OpHlt: begin
                            halt    = 1'b1;
                            state_d = StHalted;
                        end
                        default: instr_end = 1'b1;  // OpNop and undefined opcodes
                    endcase
                end
                Step3: begin
                    unique case (opcode)
                        OpLda: begin
                            ram_out   = 1'b1;
                            a_in      = 1'b1;
                            instr_end = 1'b1;
                        end
                        OpAdd, OpSub: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        OpSta: begin
                            a_out     = 1'b1;
                            ram_in    = 1'b1;
                            instr_end = 1'b1;
                        end
                        default: instr_end = 1'b1;
                    endcase
                end
                Step4: begin
                    if (opcode == OpAdd || opcode == OpSub) begin
                        alu_en    = 1'b1;
                        a_in      = 1'b1;
                        alu_op    = (opcode == OpSub) ? ~ALU_OP_ADD : ALU_OP_ADD;
                        flag_load = 1'b1;
                    end
                    instr_end = 1'b1;
                end
                // Unused or illegal step values fall back to fetch.
                default: instr_end = 1'b1;
            endcase

            if (state_d == StRun) begin
                step_d = instr_end ? Step0 : step_q + Step1;
            end
        end
    end

    assign flag_c = flag_c_q;
    assign flag_z = flag_z_q;
    assign step   = step_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: directed instruction table, hand-written
// corner sequences and a random run against a micro-program reference model.
module tb_cpu_control_sequencer;

    localparam logic [14:0] PC_OUT  = 15'h4000;
    localparam logic [14:0] PC_INC  = 15'h2000;
    localparam logic [14:0] PC_LOAD = 15'h1000;
    localparam logic [14:0] MAR_IN  = 15'h0800;
    localparam logic [14:0] RAM_OUT = 15'h0400;
    localparam logic [14:0] RAM_IN  = 15'h0200;
    localparam logic [14:0] IR_IN   = 15'h0100;
    localparam logic [14:0] IR_OUT  = 15'h0080;
    localparam logic [14:0] A_IN    = 15'h0040;
    localparam logic [14:0] A_OUT   = 15'h0020;
    localparam logic [14:0] B_IN    = 15'h0010;
    localparam logic [14:0] ALU_EN  = 15'h0008;
    localparam logic [14:0] ALU_OP  = 15'h0004;
    localparam logic [14:0] OUT_IN  = 15'h0002;
    localparam logic [14:0] HALT    = 15'h0001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'h0;
    logic       carry_in = 1'b0;
    logic       zero_in = 1'b0;
    logic pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_en, alu_op, out_in, halt, flag_c, flag_z;
    logic [2:0] step;

    cpu_control_sequencer #(
        .MAX_STEPS (5),
        .ALU_OP_ADD(1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .carry_in(carry_in),
        .zero_in (zero_in),
        .pc_out  (pc_out),
        .pc_inc  (pc_inc),
        .pc_load (pc_load),
        .mar_in  (mar_in),
        .ram_out (ram_out),
        .ram_in  (ram_in),
        .ir_in   (ir_in),
        .ir_out  (ir_out),
        .a_in    (a_in),
        .a_out   (a_out),
        .b_in    (b_in),
        .alu_en  (alu_en),
        .alu_op  (alu_op),
        .out_in  (out_in),
        .halt    (halt),
        .flag_c  (flag_c),
        .flag_z  (flag_z),
        .step    (step)
    );

    always #5 clk = ~clk;

    logic [14:0] ctrl_word;
    assign ctrl_word = {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
                        a_in, a_out, b_in, alu_en, alu_op, out_in, halt};

    int checks = 0;
    int errors = 0;

    // Reference model: a micro-program per opcode plus step index, flags and halted bit.
    logic [14:0] prog [5];
    int          prog_len;
    int          m_step   = 0;
    logic        m_fc     = 1'b0;
    logic        m_fz     = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_valid  = 1'b0;

    logic [14:0] last_ctrl;
    logic [2:0]  last_step;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_prog(input logic [3:0] op);
        for (int k = 0; k < 5; k++) prog[k] = '0;
        prog[0]  = PC_OUT | MAR_IN;
        prog[1]  = RAM_OUT | IR_IN | PC_INC;
        prog_len = 3;
        case (op)
            4'h1: begin prog[2] = IR_OUT | MAR_IN; prog[3] = RAM_OUT | A_IN; prog_len = 4; end
            4'h2, 4'h3: begin
                prog[2] = IR_OUT | MAR_IN;
                prog[3] = RAM_OUT | B_IN;
                prog[4] = ALU_EN | A_IN;
                prog_len = 5;
            end
            4'h4: begin prog[2] = IR_OUT | MAR_IN; prog[3] = A_OUT | RAM_IN; prog_len = 4; end
            4'h5: prog[2] = IR_OUT | A_IN;
            4'h6: prog[2] = IR_OUT | PC_LOAD;
            4'h7: if (m_fc) prog[2] = IR_OUT | PC_LOAD;
            4'h8: if (m_fz) prog[2] = IR_OUT | PC_LOAD;
            4'hE: prog[2] = A_OUT | OUT_IN;
            4'hF: prog[2] = HALT;
            default: ;
        endcase
        for (int k = 0; k < 5; k++) prog[k] = prog[k] | ALU_OP;
        if (op == 4'h3) prog[4] = prog[4] & ~ALU_OP;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        logic [14:0] exp;
        @(negedge clk);
        last_ctrl = ctrl_word;
        last_step = step;
        load_prog(opcode);
        chk("one_bus_driver",
            32'($countones({pc_out, ram_out, ir_out, a_out, alu_en}) <= 1), 32'd1);
        if (rst || m_valid) begin
            if (rst)           exp = ALU_OP;
            else if (m_halted) exp = HALT | ALU_OP;
            else               exp = prog[m_step];
            chk("ctrl_word", 32'(ctrl_word), 32'(exp));
        end
        if (m_valid) begin
            chk("step", 32'(step), 32'(m_step));
            chk("flags", 32'({flag_c, flag_z}), 32'({m_fc, m_fz}));
        end
        @(posedge clk);
        if (rst) begin
            m_step = 0; m_fc = 1'b0; m_fz = 1'b0; m_halted = 1'b0; m_valid = 1'b1;
        end else if (m_valid && !m_halted) begin
            if (opcode == 4'hF && m_step == 2) begin
                m_halted = 1'b1;
            end else begin
                if ((opcode == 4'h2 || opcode == 4'h3) && m_step == 4) begin
                    m_fc = carry_in;
                    m_fz = zero_in;
                end
                m_step = (m_step == prog_len - 1) ? 0 : m_step + 1;
            end
        end
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        cin;
        logic        zin;
        logic [14:0] s2;
        int          len;
        logic        fc;
        logic        fz;
    } vec_t;

    vec_t vt [14];

    initial begin
        int          n;
        logic        done;
        logic [14:0] s2w;

        vt[0]  = '{4'h2, 1'b1, 1'b0, IR_OUT | MAR_IN | ALU_OP,  5, 1'b1, 1'b0};  // ADD
        vt[1]  = '{4'h7, 1'b0, 1'b1, IR_OUT | PC_LOAD | ALU_OP, 3, 1'b1, 1'b0};  // JC taken
        vt[2]  = '{4'h8, 1'b0, 1'b1, ALU_OP,                    3, 1'b1, 1'b0};  // JZ not taken
        vt[3]  = '{4'h3, 1'b0, 1'b1, IR_OUT | MAR_IN | ALU_OP,  5, 1'b0, 1'b1};  // SUB
        vt[4]  = '{4'h7, 1'b1, 1'b0, ALU_OP,                    3, 1'b0, 1'b1};  // JC not taken
        vt[5]  = '{4'h8, 1'b1, 1'b0, IR_OUT | PC_LOAD | ALU_OP, 3, 1'b0, 1'b1};  // JZ taken
        vt[6]  = '{4'h1, 1'b1, 1'b0, IR_OUT | MAR_IN | ALU_OP,  4, 1'b0, 1'b1};  // LDA
        vt[7]  = '{4'h4, 1'b1, 1'b0, IR_OUT | MAR_IN | ALU_OP,  4, 1'b0, 1'b1};  // STA
        vt[8]  = '{4'h5, 1'b1, 1'b0, IR_OUT | A_IN | ALU_OP,    3, 1'b0, 1'b1};  // LDI
        vt[9]  = '{4'h6, 1'b1, 1'b0, IR_OUT | PC_LOAD | ALU_OP, 3, 1'b0, 1'b1};  // JMP
        vt[10] = '{4'hE, 1'b1, 1'b0, A_OUT | OUT_IN | ALU_OP,   3, 1'b0, 1'b1};  // OUT
        vt[11] = '{4'h0, 1'b1, 1'b0, ALU_OP,                    3, 1'b0, 1'b1};  // NOP
        vt[12] = '{4'hA, 1'b1, 1'b0, ALU_OP,                    3, 1'b0, 1'b1};  // undefined
        vt[13] = '{4'h2, 1'b1, 1'b1, IR_OUT | MAR_IN | ALU_OP,  5, 1'b1, 1'b1};  // ADD

        // Reset held for two cycles, then the first fetch.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_step", 32'(step), 32'd0);
        chk("reset_flags", 32'({flag_c, flag_z}), 32'd0);
        chk("reset_halt", 32'(halt), 32'd0);
        tick();
        chk("first_fetch", 32'(last_ctrl), 32'(PC_OUT | MAR_IN | ALU_OP));
        tick();
        tick();  // NOP (opcode 0) finishes at step 2

        // Directed instruction table.
        for (int v = 0; v < 14; v++) begin
            opcode   = vt[v].op;
            carry_in = vt[v].cin;
            zero_in  = vt[v].zin;
            n    = 0;
            done = 1'b0;
            s2w  = '0;
            while (!done) begin
                tick();
                n++;
                if (last_step == 3'd2) s2w = last_ctrl;
                if (step == 3'd0 || n >= 10) done = 1'b1;
            end
            chk($sformatf("vec%0d_len", v), 32'(n), 32'(vt[v].len));
            chk($sformatf("vec%0d_step2", v), 32'(s2w), 32'(vt[v].s2));
            chk($sformatf("vec%0d_flags", v), 32'({flag_c, flag_z}),
                32'({vt[v].fc, vt[v].fz}));
        end

        // HLT: halts at step 2 and stays there until reset; flags are set beforehand.
        opcode = 4'hF;
        tick();
        tick();
        tick();
        chk("hlt_step2_halt", 32'(last_ctrl), 32'(HALT | ALU_OP));
        for (int i = 0; i < 20; i++) tick();
        chk("hlt_frozen_step", 32'(step), 32'd2);
        chk("hlt_still_halt", 32'(halt), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        opcode = 4'h0;
        chk("hlt_reset_flags", 32'({flag_c, flag_z}), 32'd0);
        chk("hlt_reset_halt", 32'(halt), 32'd0);
        tick();
        chk("hlt_resume_fetch", 32'(last_ctrl), 32'(PC_OUT | MAR_IN | ALU_OP));
        tick();
        tick();

        // Reset in step 3 of LDA: A must never load.
        opcode = 4'h1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_a_in", 32'(last_ctrl & A_IN), 32'd0);
        chk("midreset_step", 32'(step), 32'd0);

        // Random run against the model.
        for (int i = 0; i < 800; i++) begin
            carry_in = 1'($urandom);
            zero_in  = 1'($urandom);
            if (m_halted) rst = ($urandom_range(0, 7) == 0);
            else          rst = ($urandom_range(0, 99) == 0);
            if (m_step == 0) opcode = 4'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
